// File: rtl/fetch_pkg.sv
// Shared widths, reset defaults and state encoding for the instruction-fetch stage.
package fetch_pkg;
  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'd0;
  localparam logic [PC_W-1:0]    DEFAULT_RESET_PC = 32'd0;
  localparam logic [PC_W-1:0]    DEFAULT_PC_INC   = 32'd1;

  typedef enum logic {
    RUN  = 1'b0,
    FULL = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_word_t;
endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of fetch-stage signals: instruction-memory handshake, redirect/flush/stall, IF/ID outputs.
interface fetch_stage_if;
  import fetch_pkg::*;

  logic [PC_W-1:0]    imem_addr;
  logic               imem_hit;
  logic [INSTR_W-1:0] imem_q;
  logic               imem_clear;
  logic               imem_hold;
  logic               jump_valid;
  logic [PC_W-1:0]    jump_addr;
  logic               flush;
  logic               id_stall;
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [PC_W-1:0]    if_pc;

  // master is the fetch stage; slave is the memory/pipeline environment around it
  modport master (
    output imem_addr, imem_clear, imem_hold, if_valid, if_instr, if_pc,
    input  imem_hit, imem_q, jump_valid, jump_addr, flush, id_stall
  );

  modport slave (
    input  imem_addr, imem_clear, imem_hold, if_valid, if_instr, if_pc,
    output imem_hit, imem_q, jump_valid, jump_addr, flush, id_stall
  );
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry {instr,pc} holding buffer; clear beats load, load beats unload.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        unload,
  input  logic        clear,
  input  fetch_word_t din,
  output fetch_word_t dout,
  output logic        full
);

  fetch_word_t word_reg;
  logic        full_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_reg <= '0;
      full_reg <= 1'b0;
    end else if (clear) begin
      full_reg <= 1'b0;
    end else if (load) begin
      word_reg <= din;
      full_reg <= 1'b1;
    end else if (unload) begin
      full_reg <= 1'b0;
    end
  end

  assign dout = word_reg;
  assign full = full_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, IF/ID register, one-word skid, jump/flush handling.
// Optional macro FETCH_PERF_EN adds fetch and stall performance counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [PC_W-1:0] PC_INC   = DEFAULT_PC_INC
) (
  input  logic                clk,
  input  logic                reset,
  fetch_stage_if.master       bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]         perf_fetch_cnt,
  output logic [31:0]         perf_stall_cnt
`endif
);

  fetch_state_t state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  fetch_word_t out_reg, out_next;
  logic valid_reg, valid_next;

  logic        kill;
  logic        hit_accept;
  logic        skid_load, skid_unload, skid_clear, skid_full;
  fetch_word_t skid_dout;

  assign kill       = bus.jump_valid || bus.flush;
  assign hit_accept = bus.imem_hit && !kill && (state_reg == RUN);

  fetch_skid_buf u_skid (
    .clk    (clk),
    .reset  (reset),
    .load   (skid_load),
    .unload (skid_unload),
    .clear  (skid_clear),
    .din    ('{instr: bus.imem_q, pc: pc_reg}),
    .dout   (skid_dout),
    .full   (skid_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= RUN;
      pc_reg    <= RESET_PC;
      out_reg   <= '{instr: NOP_INSTR, pc: '0};
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      out_reg   <= out_next;
      valid_reg <= valid_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    out_next    = out_reg;
    valid_next  = valid_reg;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_clear  = 1'b0;

    if (kill) begin
      // jump and flush both drop any same-cycle hit; only jump moves the PC
      if (bus.jump_valid) pc_next = bus.jump_addr;
      valid_next     = 1'b0;
      out_next.instr = NOP_INSTR;
      skid_clear     = 1'b1;
      state_next     = RUN;
    end else begin
      case (state_reg)
        RUN: begin
          if (bus.imem_hit) begin
            pc_next = pc_reg + PC_INC;
            if (bus.id_stall && valid_reg) begin
              skid_load  = 1'b1;
              state_next = FULL;
            end else begin
              out_next   = '{instr: bus.imem_q, pc: pc_reg};
              valid_next = 1'b1;
            end
          end else if (!bus.id_stall) begin
            valid_next     = 1'b0;
            out_next.instr = NOP_INSTR;
          end
        end
        FULL: begin
          if (!bus.id_stall) begin
            out_next    = skid_dout;
            valid_next  = skid_full;
            skid_unload = 1'b1;
            state_next  = RUN;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  assign bus.imem_addr  = pc_reg;
  assign bus.imem_clear = reset && kill;
  // hold while the skid is occupied, or while a stalled decode would force the next word into it
  assign bus.imem_hold  = reset && ((state_reg == FULL) ||
                                    (bus.id_stall && valid_reg && !bus.imem_hit));
  assign bus.if_valid   = valid_reg;
  assign bus.if_instr   = out_reg.instr;
  assign bus.if_pc      = out_reg.pc;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_reg, stall_cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_cnt_reg <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (hit_accept)                 fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
      if (bus.id_stall && valid_reg)  stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_reg;
  assign perf_stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: accepted fetches are queued, words leaving IF/ID are popped and compared.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic clk;
  logic reset;
  int   vec_cnt;
  int   err_cnt;
  logic [63:0] exp_q[$];

  fetch_stage_if bus ();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [31:0] a);
    return (a * 32'h9E3779B9) ^ 32'h1234_5678;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic hit, input logic stall, input logic jmp,
                       input logic [31:0] ja, input logic fl);
    bus.imem_hit   = hit;
    bus.id_stall   = stall;
    bus.jump_valid = jmp;
    bus.jump_addr  = ja;
    bus.flush      = fl;
    bus.imem_q     = hit ? mk(bus.imem_addr) : 32'hDEAD_BEEF;
    #1;
  endtask

  task automatic push_fetch();
    exp_q.push_back({mk(bus.imem_addr), bus.imem_addr});
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 32'h55, 1'b0);
    vec_cnt++; if (bus.if_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid: got %b want 0", bus.if_valid); end
    vec_cnt++; if (bus.if_instr !== 32'd0) begin err_cnt++; $display("FAIL reset_instr: got %h want 0", bus.if_instr); end
    vec_cnt++; if (bus.if_pc !== 32'd0) begin err_cnt++; $display("FAIL reset_pc: got %h want 0", bus.if_pc); end
    vec_cnt++; if (bus.imem_addr !== 32'd0) begin err_cnt++; $display("FAIL reset_addr: got %h want 0", bus.imem_addr); end
    vec_cnt++; if (bus.imem_clear !== 1'b0) begin err_cnt++; $display("FAIL reset_clear: got %b want 0", bus.imem_clear); end
    vec_cnt++; if (bus.imem_hold !== 1'b0) begin err_cnt++; $display("FAIL reset_hold: got %b want 0", bus.imem_hold); end
    tick();
    tick();
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic test_stream();
    logic [63:0] e;
    for (int c = 0; c < 6; c++) begin
      drive(c < 4, 1'b0, 1'b0, 32'd0, 1'b0);
      vec_cnt++;
      if (bus.imem_addr !== 32'(c < 4 ? c : 4)) begin err_cnt++; $display("FAIL stream_addr c%0d: got %h want %h", c, bus.imem_addr, (c < 4 ? c : 4)); end
      vec_cnt++;
      if (bus.if_valid !== (c >= 1 && c <= 4)) begin err_cnt++; $display("FAIL stream_valid c%0d: got %b", c, bus.if_valid); end
      if (bus.if_valid && !bus.id_stall) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        vec_cnt++;
        if ({bus.if_instr, bus.if_pc} !== e) begin err_cnt++; $display("FAIL stream_word: got %h/%h want %h/%h", bus.if_instr, bus.if_pc, e[63:32], e[31:0]); end
        else $display("  stream word pc=%h instr=%h", bus.if_pc, bus.if_instr);
      end
      if (c < 4) push_fetch();
      tick();
    end
    vec_cnt++; if (exp_q.size() != 0) begin err_cnt++; $display("FAIL stream_leftover: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_stall();
    logic [63:0] e;
    logic [5:0] hits   = 6'b010011;
    logic [5:0] stalls = 6'b000110;
    logic [5:0] holds  = 6'b001100;
    int exp_addr[6] = '{4, 5, 6, 6, 6, 7};
    for (int c = 0; c < 6; c++) begin
      drive(hits[c], stalls[c], 1'b0, 32'd0, 1'b0);
      vec_cnt++;
      if (bus.imem_addr !== 32'(exp_addr[c])) begin err_cnt++; $display("FAIL stall_addr c%0d: got %h want %h", c, bus.imem_addr, exp_addr[c]); end
      vec_cnt++;
      if (bus.imem_hold !== holds[c]) begin err_cnt++; $display("FAIL stall_hold c%0d: got %b want %b", c, bus.imem_hold, holds[c]); end
      if (bus.if_valid && !bus.id_stall) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        vec_cnt++;
        if ({bus.if_instr, bus.if_pc} !== e) begin err_cnt++; $display("FAIL stall_word: got %h/%h want %h/%h", bus.if_instr, bus.if_pc, e[63:32], e[31:0]); end
        else $display("  stall word pc=%h instr=%h", bus.if_pc, bus.if_instr);
      end
      if (hits[c]) push_fetch();
      tick();
    end
    vec_cnt++; if (exp_q.size() != 0 || bus.if_valid !== 1'b0) begin err_cnt++; $display("FAIL stall_leftover: got %0d/%b want 0/0", exp_q.size(), bus.if_valid); end
  endtask

  task automatic test_jump();
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    push_fetch();
    tick();
    drive(1'b1, 1'b1, 1'b1, 32'h100, 1'b0);
    vec_cnt++; if (bus.imem_clear !== 1'b1) begin err_cnt++; $display("FAIL jump_clear: got %b want 1", bus.imem_clear); end
    exp_q.delete();
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    vec_cnt++; if (bus.imem_addr !== 32'h100) begin err_cnt++; $display("FAIL jump_addr: got %h want 00000100", bus.imem_addr); end
    vec_cnt++; if (bus.if_valid !== 1'b0 || bus.if_instr !== 32'd0) begin err_cnt++; $display("FAIL jump_kill: got %b/%h want 0/0", bus.if_valid, bus.if_instr); end
    vec_cnt++; if (bus.imem_clear !== 1'b0) begin err_cnt++; $display("FAIL jump_clear_drop: got %b want 0", bus.imem_clear); end
    push_fetch();
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    vec_cnt++;
    if (exp_q.size() == 0 || bus.if_valid !== 1'b1 || {bus.if_instr, bus.if_pc} !== exp_q[0] || bus.if_pc !== 32'h100) begin
      err_cnt++; $display("FAIL jump_first: got %b %h/%h want 1 %h/00000100", bus.if_valid, bus.if_instr, bus.if_pc, mk(32'h100));
    end else $display("  jump word pc=%h instr=%h", bus.if_pc, bus.if_instr);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    tick();
  endtask

  task automatic test_flush();
    logic [63:0] e;
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    push_fetch();
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    push_fetch();
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    vec_cnt++; if (bus.imem_hold !== 1'b1 || bus.imem_addr !== 32'h103) begin err_cnt++; $display("FAIL flush_full: got hold=%b addr=%h want 1/00000103", bus.imem_hold, bus.imem_addr); end
    vec_cnt++; if (bus.imem_clear !== 1'b1) begin err_cnt++; $display("FAIL flush_clear: got %b want 1", bus.imem_clear); end
    exp_q.delete();
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    vec_cnt++; if (bus.if_valid !== 1'b0 || bus.if_instr !== 32'd0) begin err_cnt++; $display("FAIL flush_kill: got %b/%h want 0/0", bus.if_valid, bus.if_instr); end
    vec_cnt++; if (bus.imem_hold !== 1'b0 || bus.imem_addr !== 32'h103) begin err_cnt++; $display("FAIL flush_run: got hold=%b addr=%h want 0/00000103", bus.imem_hold, bus.imem_addr); end
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    vec_cnt++; if (bus.imem_addr !== 32'h103) begin err_cnt++; $display("FAIL flush_refetch: got %h want 00000103", bus.imem_addr); end
    push_fetch();
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
    vec_cnt++;
    if (bus.if_valid !== 1'b1 || {bus.if_instr, bus.if_pc} !== e) begin err_cnt++; $display("FAIL flush_word: got %b %h/%h want 1 %h/%h", bus.if_valid, bus.if_instr, bus.if_pc, e[63:32], e[31:0]); end
    else $display("  flush word pc=%h instr=%h", bus.if_pc, bus.if_instr);
    tick();
  endtask

  task automatic test_wrap();
    logic [63:0] e;
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    vec_cnt++; if (bus.imem_addr !== 32'hFFFF_FFFF) begin err_cnt++; $display("FAIL wrap_top: got %h want ffffffff", bus.imem_addr); end
    push_fetch();
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    vec_cnt++; if (bus.imem_addr !== 32'd0) begin err_cnt++; $display("FAIL wrap_addr: got %h want 00000000", bus.imem_addr); end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
    vec_cnt++;
    if (bus.if_valid !== 1'b1 || {bus.if_instr, bus.if_pc} !== e) begin err_cnt++; $display("FAIL wrap_word: got %b %h/%h want 1 %h/%h", bus.if_valid, bus.if_instr, bus.if_pc, e[63:32], e[31:0]); end
    else $display("  wrap word pc=%h instr=%h", bus.if_pc, bus.if_instr);
    tick();
  endtask

  task automatic test_reset_mid_stall();
    logic [63:0] e;
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    push_fetch();
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    push_fetch();
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    vec_cnt++; if (bus.imem_hold !== 1'b1 || bus.imem_addr !== 32'd2) begin err_cnt++; $display("FAIL rst_full: got hold=%b addr=%h want 1/00000002", bus.imem_hold, bus.imem_addr); end
    reset = 1'b0;
    #1;
    vec_cnt++; if (bus.if_valid !== 1'b0 || bus.if_instr !== 32'd0 || bus.if_pc !== 32'd0) begin err_cnt++; $display("FAIL rst_out: got %b %h/%h want 0 0/0", bus.if_valid, bus.if_instr, bus.if_pc); end
    vec_cnt++; if (bus.imem_addr !== 32'd0 || bus.imem_hold !== 1'b0) begin err_cnt++; $display("FAIL rst_pc: got addr=%h hold=%b want 0/0", bus.imem_addr, bus.imem_hold); end
`ifdef FETCH_PERF_EN
    vec_cnt++; if (perf_fetch_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin err_cnt++; $display("FAIL rst_perf: got %0d/%0d want 0/0", perf_fetch_cnt, perf_stall_cnt); end
`endif
    exp_q.delete();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      if (bus.if_valid && !bus.id_stall) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        vec_cnt++;
        if ({bus.if_instr, bus.if_pc} !== e) begin err_cnt++; $display("FAIL rerun_word: got %h/%h want %h/%h", bus.if_instr, bus.if_pc, e[63:32], e[31:0]); end
        else $display("  rerun word pc=%h instr=%h", bus.if_pc, bus.if_instr);
      end
      push_fetch();
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
      tick();
    end
`ifdef FETCH_PERF_EN
    vec_cnt++; if (perf_fetch_cnt !== 32'd10) begin err_cnt++; $display("FAIL perf_fetch: got %0d want 10", perf_fetch_cnt); end
    vec_cnt++; if (perf_stall_cnt !== 32'd3) begin err_cnt++; $display("FAIL perf_stall: got %0d want 3", perf_stall_cnt); end
`endif
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    vec_cnt++; if (bus.imem_addr !== 32'd10) begin err_cnt++; $display("FAIL rerun_addr: got %h want 0000000a", bus.imem_addr); end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
    vec_cnt++;
    if (bus.if_valid !== 1'b1 || {bus.if_instr, bus.if_pc} !== e) begin err_cnt++; $display("FAIL rerun_last: got %b %h/%h want 1 %h/%h", bus.if_valid, bus.if_instr, bus.if_pc, e[63:32], e[31:0]); end
    else $display("  rerun word pc=%h instr=%h", bus.if_pc, bus.if_instr);
    tick();
    vec_cnt++; if (exp_q.size() != 0) begin err_cnt++; $display("FAIL rerun_leftover: got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    test_reset();
    test_stream();
    test_stall();
    test_jump();
    test_flush();
    test_wrap();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
